// File: rtl/fpu_cnt_lead0_pipe.sv
// Two-stage leading-zero / leading-one counter for the FPU normalisation path.
// Latency: 2 cycles from input transfer to out_vld; one result per cycle.
// Backpressure: full valid/ready; s1+s2 hold two operands under stall, in_rdy drops only when both are full.
//
// Ports:
//   rclk, rst                 clock, synchronous active-high reset
//   in_vld/in_rdy             operand handshake; in_din operand (MSB = bit WIDTH-1)
//   in_lead1                  1 = count leading ones, 0 = count leading zeros
//   in_tag                    side-band tag, returned unchanged on out_tag
//   out_vld/out_rdy           result handshake
//   out_cnt                   leading count 0..WIDTH; out_zero set when count == WIDTH
module fpu_cnt_lead0_pipe #(
   parameter int WIDTH = 64,
   parameter int TAGW  = 4,
   parameter int CW    = $clog2(WIDTH) + 1
) (
   input  logic             rclk,
   input  logic             rst,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [WIDTH-1:0] in_din,
   input  logic             in_lead1,
   input  logic [TAGW-1:0]  in_tag,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [CW-1:0]    out_cnt,
   output logic             out_zero,
   output logic [TAGW-1:0]  out_tag
);

   localparam int NG = WIDTH / 16;

   logic                 s1_adv;
   logic                 s2_adv;
   logic                 s1_vld;
   logic                 s2_vld;
   logic [WIDTH-1:0]     x;
   logic [NG-1:0]        grp_eq0;
   logic [NG-1:0][3:0]   grp_cnt;
   logic [NG-1:0]        s1_eq0;
   logic [NG-1:0][3:0]   s1_cnt;
   logic [TAGW-1:0]      s1_tag;
   logic [CW-1:0]        mrg_cnt;
   logic                 mrg_zero;

   // Leading-one mode is folded into leading-zero mode by inverting the operand.
   assign x = in_lead1 ? ~in_din : in_din;

   // Per-group count: the highest set bit wins because it is visited last.
   // An all-zero group leaves its count at 0; the eq0 flag carries that case.
   always_comb begin
      grp_eq0 = '0;
      grp_cnt = '0;
      for (int g = 0; g < NG; g++) begin
         grp_eq0[g] = (x[16*g +: 16] == 16'd0);
         for (int i = 0; i < 16; i++) begin
            if (x[16*g + i]) begin
               grp_cnt[g] = 4'(15 - i);
            end
         end
      end
   end

   // Merge: scanning upward, the most-significant non-zero group is the last to write.
   always_comb begin
      mrg_cnt  = CW'(WIDTH);
      mrg_zero = 1'b1;
      for (int g = 0; g < NG; g++) begin
         if (!s1_eq0[g]) begin
            mrg_cnt  = CW'(16 * (NG - 1 - g)) + CW'(s1_cnt[g]);
            mrg_zero = 1'b0;
         end
      end
   end

   assign s2_adv  = !s2_vld | out_rdy;
   assign s1_adv  = !s1_vld | s2_adv;
   assign in_rdy  = s1_adv;
   assign out_vld = s2_vld;

   always_ff @(posedge rclk) begin
      if (rst) begin
         s1_vld   <= 1'b0;
         s1_eq0   <= '0;
         s1_cnt   <= '0;
         s1_tag   <= '0;
         s2_vld   <= 1'b0;
         out_cnt  <= '0;
         out_zero <= 1'b0;
         out_tag  <= '0;
      end else begin
         if (s1_adv) begin
            s1_vld <= in_vld;
            // Payload only moves with a valid operand so idle bus noise never lands in state.
            if (in_vld) begin
               s1_eq0 <= grp_eq0;
               s1_cnt <= grp_cnt;
               s1_tag <= in_tag;
            end
         end
         if (s2_adv) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
               out_cnt  <= mrg_cnt;
               out_zero <= mrg_zero;
               out_tag  <= s1_tag;
            end
         end
      end
   end

endmodule

// File: tb/tb_fpu_cnt_lead0_pipe.sv
module tb_fpu_cnt_lead0_pipe;

   logic rclk = 1'b0;
   always #5 rclk = ~rclk;

   logic rst;

   // WIDTH=64 instance
   logic        a_in_vld, a_in_rdy, a_in_lead1, a_out_vld, a_out_rdy, a_out_zero;
   logic [63:0] a_in_din;
   logic [3:0]  a_in_tag, a_out_tag;
   logic [6:0]  a_out_cnt;

   // WIDTH=16 instance
   logic        b_in_vld, b_in_rdy, b_in_lead1, b_out_vld, b_out_rdy, b_out_zero;
   logic [15:0] b_in_din;
   logic [3:0]  b_in_tag, b_out_tag;
   logic [4:0]  b_out_cnt;

   // WIDTH=128 instance
   logic         c_in_vld, c_in_rdy, c_in_lead1, c_out_vld, c_out_rdy, c_out_zero;
   logic [127:0] c_in_din;
   logic [3:0]   c_in_tag, c_out_tag;
   logic [7:0]   c_out_cnt;

   fpu_cnt_lead0_pipe #(.WIDTH(64)) dut64 (
      .rclk(rclk), .rst(rst),
      .in_vld(a_in_vld), .in_rdy(a_in_rdy), .in_din(a_in_din), .in_lead1(a_in_lead1), .in_tag(a_in_tag),
      .out_vld(a_out_vld), .out_rdy(a_out_rdy), .out_cnt(a_out_cnt), .out_zero(a_out_zero), .out_tag(a_out_tag)
   );

   fpu_cnt_lead0_pipe #(.WIDTH(16)) dut16 (
      .rclk(rclk), .rst(rst),
      .in_vld(b_in_vld), .in_rdy(b_in_rdy), .in_din(b_in_din), .in_lead1(b_in_lead1), .in_tag(b_in_tag),
      .out_vld(b_out_vld), .out_rdy(b_out_rdy), .out_cnt(b_out_cnt), .out_zero(b_out_zero), .out_tag(b_out_tag)
   );

   fpu_cnt_lead0_pipe #(.WIDTH(128)) dut128 (
      .rclk(rclk), .rst(rst),
      .in_vld(c_in_vld), .in_rdy(c_in_rdy), .in_din(c_in_din), .in_lead1(c_in_lead1), .in_tag(c_in_tag),
      .out_vld(c_out_vld), .out_rdy(c_out_rdy), .out_cnt(c_out_cnt), .out_zero(c_out_zero), .out_tag(c_out_tag)
   );

   typedef struct {
      int         cnt;
      logic       zero;
      logic [3:0] tag;
   } exp_t;

   exp_t qb[$];
   exp_t qc[$];

   int n_cmp;
   int n_bad;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Bit-serial reference: count bits from the MSB down while they equal the counted value.
   function automatic int ref_lz(input logic [127:0] d, input logic lead1, input int w);
      int n = 0;
      for (int i = w - 1; i >= 0; i--) begin
         if (d[i] != lead1) break;
         n++;
      end
      return n;
   endfunction

   // One isolated operand on the 64-bit instance; checks the 2-cycle latency and the result.
   task automatic single(input string name, input logic [63:0] din, input logic lead1,
                         input logic [3:0] tag, input int exp_cnt, input logic exp_zero);
      @(posedge rclk); #1;
      a_in_vld   = 1'b1;
      a_in_din   = din;
      a_in_lead1 = lead1;
      a_in_tag   = tag;
      a_out_rdy  = 1'b1;
      @(negedge rclk);
      check({name, "_in_rdy"}, 32'(a_in_rdy), 32'd1);
      @(posedge rclk); #1;
      a_in_vld   = 1'b0;
      a_in_din   = ~din;
      a_in_lead1 = ~lead1;
      @(negedge rclk);
      check({name, "_vld_early"}, 32'(a_out_vld), 32'd0);
      @(posedge rclk);
      @(negedge rclk);
      check({name, "_vld"},  32'(a_out_vld),  32'd1);
      check({name, "_cnt"},  32'(a_out_cnt),  32'(exp_cnt));
      check({name, "_zero"}, 32'(a_out_zero), 32'(exp_zero));
      check({name, "_tag"},  32'(a_out_tag),  32'(tag));
   endtask

   initial begin
      int         sent;
      int         rcv;
      logic       prev_stall;
      logic [6:0] prev_cnt;
      logic [3:0] prev_tag;
      logic       prev_zero;
      logic       stale;
      logic [31:0]  r32;
      logic [127:0] r128;
      exp_t       e;

      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      a_in_vld = 1'b0; a_in_din = '0; a_in_lead1 = 1'b0; a_in_tag = '0; a_out_rdy = 1'b1;
      b_in_vld = 1'b0; b_in_din = '0; b_in_lead1 = 1'b0; b_in_tag = '0; b_out_rdy = 1'b1;
      c_in_vld = 1'b0; c_in_din = '0; c_in_lead1 = 1'b0; c_in_tag = '0; c_out_rdy = 1'b1;

      // Reset state
      repeat (3) @(posedge rclk);
      #1 rst = 1'b0;
      @(negedge rclk);
      check("rst_out_vld",  32'(a_out_vld),  32'd0);
      check("rst_out_cnt",  32'(a_out_cnt),  32'd0);
      check("rst_out_zero", 32'(a_out_zero), 32'd0);
      check("rst_out_tag",  32'(a_out_tag),  32'd0);
      check("rst_in_rdy",   32'(a_in_rdy),   32'd1);

      // Directed single operands
      single("t1_lsb",      64'h0000_0000_0000_0001, 1'b0, 4'h1, 63, 1'b0);
      single("t2_zero",     64'h0000_0000_0000_0000, 1'b0, 4'h2, 64, 1'b1);
      single("t2_ones",     64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'h3, 64, 1'b1);
      single("t3_f0_lz",    64'h00F0_0000_0000_0000, 1'b0, 4'h4, 8,  1'b0);
      single("t3_f0_lo",    64'h00F0_0000_0000_0000, 1'b1, 4'h5, 0,  1'b0);
      single("t3_fff7_lo",  64'hFFF7_0000_0000_0000, 1'b1, 4'h6, 12, 1'b0);
      single("msb",         64'h8000_0000_0000_0000, 1'b0, 4'h7, 0,  1'b0);
      single("grp_bnd_31",  64'h0000_0001_0000_0000, 1'b0, 4'h8, 31, 1'b0);
      single("grp_bnd_47",  64'h0000_0000_0001_0000, 1'b0, 4'h9, 47, 1'b0);
      single("ones_lz",     64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'hA, 0,  1'b0);

      // T4: back-to-back stream of tags 0..9, out_rdy low for cycles 4..6
      sent = 0;
      rcv = 0;
      prev_stall = 1'b0;
      prev_cnt = '0;
      prev_tag = '0;
      prev_zero = 1'b0;
      for (int c = 0; c < 40 && rcv < 10; c++) begin
         @(posedge rclk); #1;
         a_in_vld   = (sent < 10);
         a_in_din   = 64'd1 << (sent * 5);
         a_in_lead1 = 1'b0;
         a_in_tag   = 4'(sent);
         a_out_rdy  = !(c >= 4 && c <= 6);
         @(negedge rclk);
         if (prev_stall) begin
            check("t4_hold_vld",  32'(a_out_vld),  32'd1);
            check("t4_hold_cnt",  32'(a_out_cnt),  32'(prev_cnt));
            check("t4_hold_zero", 32'(a_out_zero), 32'(prev_zero));
            check("t4_hold_tag",  32'(a_out_tag),  32'(prev_tag));
         end
         if (c >= 4 && c <= 6) begin
            check("t4_in_rdy_stall", 32'(a_in_rdy), 32'd0);
         end
         if (a_out_vld && a_out_rdy) begin
            check("t4_tag", 32'(a_out_tag), 32'(rcv));
            check("t4_cnt", 32'(a_out_cnt), 32'(63 - 5 * rcv));
            rcv++;
         end
         prev_stall = a_out_vld && !a_out_rdy;
         prev_cnt   = a_out_cnt;
         prev_tag   = a_out_tag;
         prev_zero  = a_out_zero;
         if (a_in_vld && a_in_rdy) sent++;
      end
      check("t4_received", 32'(rcv), 32'd10);

      // T5: reset with both stages full
      @(posedge rclk); #1;
      a_in_vld = 1'b1; a_in_din = 64'h1; a_in_lead1 = 1'b0; a_in_tag = 4'hA; a_out_rdy = 1'b0;
      @(posedge rclk); #1;
      a_in_tag = 4'hB;
      @(posedge rclk); #1;
      a_in_vld = 1'b0;
      @(negedge rclk);
      check("t5_full_vld",    32'(a_out_vld), 32'd1);
      check("t5_full_tag",    32'(a_out_tag), 32'hA);
      check("t5_full_in_rdy", 32'(a_in_rdy),  32'd0);
      @(posedge rclk); #1;
      rst = 1'b1; a_in_vld = 1'b1; a_in_tag = 4'hC;
      @(posedge rclk); #1;
      rst = 1'b0; a_in_vld = 1'b0; a_out_rdy = 1'b1;
      @(negedge rclk);
      check("t5_rst_vld",    32'(a_out_vld), 32'd0);
      check("t5_rst_in_rdy", 32'(a_in_rdy),  32'd1);
      check("t5_rst_cnt",    32'(a_out_cnt), 32'd0);
      check("t5_rst_tag",    32'(a_out_tag), 32'd0);
      stale = 1'b0;
      repeat (6) begin
         @(negedge rclk);
         if (a_out_vld) stale = 1'b1;
      end
      check("t5_no_stale", 32'(stale), 32'd0);

      // T6: single-bit sweep then random operands on the 16- and 128-bit instances
      for (int c = 0; c < 172; c++) begin
         @(posedge rclk); #1;
         b_in_tag = 4'(c);
         c_in_tag = 4'(c);
         if (c < 16) begin
            b_in_vld = 1'b1; b_in_lead1 = 1'b0;
            b_in_din = 16'd1 << c;
         end else if (c < 56) begin
            b_in_vld = 1'b1;
            r32 = $urandom;
            b_in_din = r32[15:0] >> $urandom_range(0, 16);
            b_in_lead1 = 1'($urandom_range(0, 1));
            if (b_in_lead1) b_in_din = ~b_in_din;
         end else begin
            b_in_vld = 1'b0;
         end
         if (b_in_vld) begin
            e.cnt  = (c < 16) ? 15 - c : ref_lz(128'(b_in_din), b_in_lead1, 16);
            e.zero = (e.cnt == 16);
            e.tag  = b_in_tag;
            qb.push_back(e);
         end
         if (c < 128) begin
            c_in_vld = 1'b1; c_in_lead1 = 1'b0;
            c_in_din = 128'd1 << c;
         end else if (c < 168) begin
            c_in_vld = 1'b1;
            r128 = {$urandom, $urandom, $urandom, $urandom};
            c_in_din = r128 >> $urandom_range(0, 128);
            c_in_lead1 = 1'($urandom_range(0, 1));
            if (c_in_lead1) c_in_din = ~c_in_din;
         end else begin
            c_in_vld = 1'b0;
         end
         if (c_in_vld) begin
            e.cnt  = (c < 128) ? 127 - c : ref_lz(c_in_din, c_in_lead1, 128);
            e.zero = (e.cnt == 128);
            e.tag  = c_in_tag;
            qc.push_back(e);
         end
         @(negedge rclk);
         if (b_in_vld) check("t6_16_in_rdy", 32'(b_in_rdy), 32'd1);
         if (c_in_vld) check("t6_128_in_rdy", 32'(c_in_rdy), 32'd1);
         if (b_out_vld) begin
            if (qb.size() == 0) begin
               check("t6_16_unexpected", 32'(b_out_vld), 32'd0);
            end else begin
               e = qb.pop_front();
               check("t6_16_cnt",  32'(b_out_cnt),  32'(e.cnt));
               check("t6_16_zero", 32'(b_out_zero), 32'(e.zero));
               check("t6_16_tag",  32'(b_out_tag),  32'(e.tag));
            end
         end
         if (c_out_vld) begin
            if (qc.size() == 0) begin
               check("t6_128_unexpected", 32'(c_out_vld), 32'd0);
            end else begin
               e = qc.pop_front();
               check("t6_128_cnt",  32'(c_out_cnt),  32'(e.cnt));
               check("t6_128_zero", 32'(c_out_zero), 32'(e.zero));
               check("t6_128_tag",  32'(c_out_tag),  32'(e.tag));
            end
         end
      end
      check("t6_16_drained",  32'(qb.size()), 32'd0);
      check("t6_128_drained", 32'(qc.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
